// File: rtl/tick_pkg.sv
// ============================================================================
// Module : tick_pkg
// Brief  : Default strobe frequencies and counter-width helper for tick_generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tick_pkg;

    localparam int DEF_CLK_HZ   = 100_000_000;
    localparam int DEF_FAST_HZ  = 100;
    localparam int DEF_SLOW_HZ  = 1;
    localparam int DEF_BLINK_HZ = 4;

    // A divider with HALF == 1 still needs a one-bit counter to compare against.
    function automatic int cnt_width(input int half);
        return (half <= 1) ? 1 : $clog2(half);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_generator_toggle_divider.sv
// ============================================================================
// Module : toggle_divider
// Brief  : Counts HALF advance strobes per half period and toggles a square.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module toggle_divider
    import tick_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  logic clr,
    output logic sq,
    output logic rise
);

    localparam int             W    = cnt_width(HALF);
    localparam logic [W-1:0]   LAST = W'(HALF - 1);

    generate
        if (HALF < 1) begin : g_bad_half
            $error("toggle_divider: HALF must be >= 1");
        end
    endgenerate

    logic [W-1:0] cnt;
    logic         terminal;

    assign terminal = (cnt == LAST);
    // Combinational: true in the cycle whose edge takes sq 0->1; a clear suppresses it.
    assign rise     = adv & ~clr & terminal & ~sq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (adv) begin
            if (terminal) begin
                cnt <= '0;
                sq  <= ~sq;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tick_generator.sv
// ============================================================================
// Module : tick_generator
// Brief  : Cascaded strobe generator: FAST_HZ square + pulse, SLOW_HZ square
//          + pulse, and a BLINK_HZ square built only when BLINK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_generator
    import tick_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int FAST_HZ  = DEF_FAST_HZ,
    parameter int SLOW_HZ  = DEF_SLOW_HZ,
    parameter int BLINK_HZ = DEF_BLINK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic sync,
    output logic hundredHz,
    output logic hundredPulse,
    output logic oneHz,
    output logic onePulse,
    output logic blink
);

    localparam int HALF_FAST = CLK_HZ / (2 * FAST_HZ);
    localparam int HALF_SLOW = FAST_HZ / (2 * SLOW_HZ);

    logic fast_rise;
    logic slow_adv;
    logic slow_rise;

    toggle_divider #(.HALF(HALF_FAST)) u_fast (
        .clk  (clk),
        .rst  (rst),
        .adv  (run),
        .clr  (sync),
        .sq   (hundredHz),
        .rise (fast_rise)
    );

    // Downstream stages step once per hundredHz rise, so their edges land on it.
    assign slow_adv = run & fast_rise;

    toggle_divider #(.HALF(HALF_SLOW)) u_slow (
        .clk  (clk),
        .rst  (rst),
        .adv  (slow_adv),
        .clr  (sync),
        .sq   (oneHz),
        .rise (slow_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hundredPulse <= 1'b0;
            onePulse     <= 1'b0;
        end else begin
            hundredPulse <= fast_rise;
            onePulse     <= slow_rise;
        end
    end

`ifdef BLINK_EN
    localparam int HALF_BLINK = FAST_HZ / (2 * BLINK_HZ);

    logic blink_rise;

    toggle_divider #(.HALF(HALF_BLINK)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .adv  (slow_adv),
        .clr  (sync),
        .sq   (blink),
        .rise (blink_rise)
    );

    logic unused_blink_rise;
    assign unused_blink_rise = blink_rise;
`else
    logic unused_blink_hz;
    assign unused_blink_hz = (BLINK_HZ != 0);
    assign blink           = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tick_generator.sv
// ============================================================================
// Module : tb_tick_generator
// Brief  : Directed checks of tick_generator at CLK_HZ=40, FAST_HZ=4,
//          SLOW_HZ=1, BLINK_HZ=2 (blink expectations follow BLINK_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tick_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b1;
    logic sync = 1'b0;
    logic hundredHz, hundredPulse, oneHz, onePulse, blink;

    int checks = 0;
    int errors = 0;

    tick_generator #(
        .CLK_HZ   (40),
        .FAST_HZ  (4),
        .SLOW_HZ  (1),
        .BLINK_HZ (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .sync         (sync),
        .hundredHz    (hundredHz),
        .hundredPulse (hundredPulse),
        .oneHz        (oneHz),
        .onePulse     (onePulse),
        .blink        (blink)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {hz,hp,1hz,1p,bl}=%b expected %b", tag, got, exp);
        end
    endtask

    // Hand-derived waveforms at cycle m of undisturbed running:
    // hundredHz period 10 rising at 5; oneHz period 40 rising at 15;
    // blink period 20 rising at 5.
    function automatic logic [4:0] exp_out(input int m);
        logic hz, hp, ohz, op, bl;
        hz  = ((m / 5) % 2) == 1;
        hp  = (m % 10) == 5;
        ohz = (m >= 15) && (((m - 15) % 40) < 20);
        op  = (m >= 15) && (((m - 15) % 40) == 0);
`ifdef BLINK_EN
        bl  = (m >= 5) && (((m - 5) % 20) < 10);
`else
        bl  = 1'b0;
`endif
        return {hz, hp, ohz, op, bl};
    endfunction

    function automatic logic [4:0] outs();
        return {hundredHz, hundredPulse, oneHz, onePulse, blink};
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        run  = 1'b1;
        sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_state", outs(), 5'b0);
        rst = 1'b0;
    endtask

    // mode 0: free run; 3: run=0 on cycles 7..12; 4: sync on cycle 15
    task automatic run_check(input string name, input int ncyc, input int mode);
        logic [4:0] exp;
        for (int n = 1; n <= ncyc; n++) begin
            run  = !(mode == 3 && n >= 7 && n <= 12);
            sync = (mode == 4 && n == 15);
            @(posedge clk);
            #1;
            if (mode == 3 && n >= 7 && n <= 12)
                exp = exp_out(6) & 5'b10101;
            else if (mode == 3 && n >= 13)
                exp = exp_out(n - 6);
            else if (mode == 4 && n >= 15)
                exp = exp_out(n - 15);
            else
                exp = exp_out(n);
            check_eq($sformatf("%s_c%0d", name, n), outs(), exp);
        end
        run  = 1'b1;
        sync = 1'b0;
    endtask

    initial begin
        do_reset();
        run_check("free", 60, 0);

        do_reset();
        run_check("freeze", 40, 3);

        do_reset();
        run_check("sync", 45, 4);

        // Reset in the middle of oneHz high, away from any clock edge
        do_reset();
        run_check("pre_rst", 20, 0);
        #3 rst = 1'b1;
        #1 check_eq("async_rst", outs(), 5'b0);
        @(negedge clk);
        rst = 1'b0;
        run_check("post_rst", 30, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
